// File: rtl/pulse_stretch_pkg.sv
// pulse_pkg: shared definitions for the pulse_stretch block.
//   state_e  - FSM state encoding (IDLE / HOLD / GAP)
//   CNT_W_DEF - default counter width
//   cnt_max() - all-ones value for a given width, used as saturation limit
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    localparam int unsigned CNT_W_DEF = 8;

    function automatic int unsigned cnt_max(input int unsigned w);
        if (w >= 32)
            return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: groups the strobe input and the stretched-level outputs.
//   pulse_in  - single-cycle event strobe (driven by master)
//   level_out - stretched level
//   busy      - high while in HOLD or GAP
//   drop      - one-cycle strobe, an event was discarded
//   drop_cnt  - saturating count of discarded events
// Modports: master (event source / consumer), slave (pulse_stretch).
interface pulse_stretch_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pulse_in;
    logic             level_out;
    logic             busy;
    logic             drop;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output pulse_in,
        input  level_out, busy, drop, drop_cnt
    );

    modport slave (
        input  pulse_in,
        output level_out, busy, drop, drop_cnt
    );
endinterface

// File: rtl/pulse_stretch_down_counter.sv
// pulse_down_counter: loadable down-counter shared by the HOLD and GAP phases.
//   clk, reset  - clock, asynchronous active-high reset
//   load_i      - load load_val_i (has priority over decrement)
//   load_val_i  - value to load
//   dec_i       - decrement enable (holds at zero)
//   zero_o      - counter is zero
module pulse_down_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle strobes into level pulses of HOLD_CYCLES
// followed by at least GAP_CYCLES low, so every accepted event gives a
// distinct rising edge. One further event may be queued; beyond that events
// are dropped and counted.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - pulse_stretch_if.slave (pulse_in, level_out, busy, drop, drop_cnt)
// Optional macro PULSE_STRETCH_RETRIGGER_EN: an event during HOLD reloads the
// hold count instead of queuing/dropping.
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    pulse_stretch_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_V  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT_V  = CNT_W'(cnt_max(CNT_W));

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             level_q, busy_q, drop_q;
    logic             drop_d;
    logic [CNT_W-1:0] drop_cnt_q;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             queue_ev;

    pulse_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        queue_ev     = 1'b0;
        drop_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.pulse_in) begin
                    state_d      = ST_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_V;
                end
            end
            ST_HOLD: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                if (bus.pulse_in) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_V;
                end else if (cnt_zero) begin
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_V;
                end else begin
                    cnt_dec = 1'b1;
                end
`else
                queue_ev = bus.pulse_in;
                if (cnt_zero) begin
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_V;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    // Final gap cycle: a queued event starts the next HOLD and a
                    // simultaneous new strobe takes its place in the queue.
                    if (pending_q || bus.pulse_in) begin
                        state_d      = ST_HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_V;
                        pending_d    = pending_q & bus.pulse_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec  = 1'b1;
                    queue_ev = bus.pulse_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (queue_ev) begin
            if (!pending_q)
                pending_d = 1'b1;
            else
                drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            level_q   <= (state_d == ST_HOLD);
            busy_q    <= (state_d != ST_IDLE);
            drop_q    <= drop_d;
            if (drop_d && (drop_cnt_q != SAT_V))
                drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.drop      = drop_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch with HOLD_CYCLES=4, GAP_CYCLES=2, CNT_W=8.
// Expectations are written as per-cycle masks from the timing tables below;
// build with +define+PULSE_STRETCH_RETRIGGER_EN for the retrigger variant.
module tb_pulse_stretch;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    pulse_stretch_if #(.CNT_W(8)) bus ();

    pulse_stretch #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       lvl;
        logic       bsy;
        logic       drp;
        logic [7:0] dcnt;
    } exp_t;

    exp_t sbq[$];

    function automatic logic [39:0] rng(input int lo, input int hi);
        logic [39:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.pulse_in = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Cycle c starts 1 time unit after a rising edge; pulse_in driven in cycle c
    // is sampled on the edge that starts cycle c+1.
    task automatic run_case(input string name, input logic [39:0] pm,
                            input logic [39:0] hm, input logic [39:0] bm,
                            input logic [39:0] dm, input int n, input bit do_reset);
        logic [7:0] dc = '0;
        exp_t e;
        if (do_reset) apply_reset();
        for (int c = 0; c < n; c++) begin
            if (dm[c]) dc = dc + 8'd1;
            e.lvl = hm[c]; e.bsy = bm[c]; e.drp = dm[c]; e.dcnt = dc;
            sbq.push_back(e);
        end
        for (int c = 0; c < n; c++) begin
            step();
            bus.pulse_in = pm[c];
            e = sbq.pop_front();
            checks++;
            if (bus.level_out !== e.lvl) begin
                failures++;
                $display("FAIL %s.level_out cycle %0d: got %b expected %b", name, c, bus.level_out, e.lvl);
            end
            checks++;
            if (bus.busy !== e.bsy) begin
                failures++;
                $display("FAIL %s.busy cycle %0d: got %b expected %b", name, c, bus.busy, e.bsy);
            end
            checks++;
            if (bus.drop !== e.drp) begin
                failures++;
                $display("FAIL %s.drop cycle %0d: got %b expected %b", name, c, bus.drop, e.drp);
            end
            checks++;
            if (bus.drop_cnt !== e.dcnt) begin
                failures++;
                $display("FAIL %s.drop_cnt cycle %0d: got %0d expected %0d", name, c, bus.drop_cnt, e.dcnt);
            end
        end
        bus.pulse_in = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.level_out, bus.busy, bus.drop, bus.drop_cnt} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state: got lvl=%b busy=%b drop=%b cnt=%0d expected all 0",
                     bus.level_out, bus.busy, bus.drop, bus.drop_cnt);
        end
    endtask

    task automatic test_single();
        logic [39:0] pm = '0;
        pm[10] = 1'b1;
        run_case("single", pm, rng(11, 14), rng(11, 16), '0, 24, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [39:0] pm = '0;
        pm[10] = 1'b1; pm[12] = 1'b1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        run_case("b2b", pm, rng(11, 16), rng(11, 18), '0, 28, 1'b1);
`else
        run_case("b2b", pm, rng(11, 14) | rng(17, 20), rng(11, 22), '0, 28, 1'b1);
`endif
    endtask

    task automatic test_drop();
        logic [39:0] pm = '0;
        logic [39:0] dm = '0;
        pm[10] = 1'b1; pm[12] = 1'b1; pm[13] = 1'b1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        run_case("drop", pm, rng(11, 17), rng(11, 19), dm, 28, 1'b1);
`else
        dm[14] = 1'b1;
        run_case("drop", pm, rng(11, 14) | rng(17, 20), rng(11, 22), dm, 28, 1'b1);
`endif
    endtask

    task automatic test_final_gap();
        logic [39:0] pm = '0;
        pm[10] = 1'b1; pm[16] = 1'b1;
        run_case("final_gap", pm, rng(11, 14) | rng(17, 20), rng(11, 22), '0, 28, 1'b1);
    endtask

    task automatic test_final_gap_pending();
        logic [39:0] pm = '0;
        pm[10] = 1'b1; pm[12] = 1'b1; pm[16] = 1'b1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        run_case("gap_pend", pm, rng(11, 20), rng(11, 22), '0, 32, 1'b1);
`else
        run_case("gap_pend", pm, rng(11, 14) | rng(17, 20) | rng(23, 26), rng(11, 28), '0, 32, 1'b1);
`endif
    endtask

    task automatic test_retrigger();
        logic [39:0] pm = '0;
        pm[10] = 1'b1; pm[13] = 1'b1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        run_case("retrig", pm, rng(11, 17), rng(11, 19), '0, 26, 1'b1);
`else
        run_case("retrig", pm, rng(11, 14) | rng(17, 20), rng(11, 22), '0, 26, 1'b1);
`endif
    endtask

    task automatic test_reset_mid_hold();
        logic [39:0] pm = '0;
        apply_reset();
        for (int c = 0; c <= 12; c++) begin
            step();
            bus.pulse_in = (c == 10 || c == 12);
        end
        checks++;
        if (bus.level_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset.pre_level: got %b expected 1", bus.level_out);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.level_out, bus.busy, bus.drop} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset.async: got lvl=%b busy=%b drop=%b expected 000",
                     bus.level_out, bus.busy, bus.drop);
        end
        bus.pulse_in = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if ({bus.level_out, bus.busy} !== 2'b00) begin
                failures++;
                $display("FAIL mid_reset.no_hold cycle %0d: got lvl=%b busy=%b expected 00",
                         c, bus.level_out, bus.busy);
            end
        end
        pm[10] = 1'b1;
        run_case("after_reset", pm, rng(11, 14), rng(11, 16), '0, 24, 1'b0);
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.pulse_in = 1'b1;
        for (int c = 0; c < 400; c++) step();
        checks++;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (bus.drop_cnt !== 8'd0 || bus.level_out !== 1'b1) begin
            failures++;
            $display("FAIL sat.held: got cnt=%0d lvl=%b expected cnt=0 lvl=1", bus.drop_cnt, bus.level_out);
        end
`else
        if (bus.drop_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat.held: got cnt=%0d expected 255", bus.drop_cnt);
        end
`endif
        bus.pulse_in = 1'b0;
        for (int c = 0; c < 20; c++) step();
        checks++;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if ({bus.busy, bus.drop, bus.drop_cnt} !== 10'd0) begin
            failures++;
            $display("FAIL sat.after: got busy=%b drop=%b cnt=%0d expected 0 0 0", bus.busy, bus.drop, bus.drop_cnt);
        end
`else
        if ({bus.busy, bus.drop, bus.drop_cnt} !== {2'b00, 8'd255}) begin
            failures++;
            $display("FAIL sat.after: got busy=%b drop=%b cnt=%0d expected 0 0 255", bus.busy, bus.drop, bus.drop_cnt);
        end
`endif
    endtask

    initial begin
        bus.pulse_in = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_final_gap();
        test_final_gap_pending();
        test_retrigger();
        test_reset_mid_hold();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
